// File: rtl/vending_disp_pkg.sv
// Shared constants for the money display: seven-segment codes (active-low,
// {dp,g,f,e,d,c,b,a}) and the converter-control FSM encoding.
package vending_disp_pkg;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        ST_LOAD_L = 2'd0,
        ST_CONV_L = 2'd1,
        ST_LOAD_R = 2'd2,
        ST_CONV_R = 2'd3
    } conv_state_e;

    // Non-decimal nibbles render blank so a corrupt BCD digit is never mistaken for a number.
    function automatic logic [7:0] seg_code(input logic [3:0] digit);
        case (digit)
            4'd0:    seg_code = SEG_0;
            4'd1:    seg_code = SEG_1;
            4'd2:    seg_code = SEG_2;
            4'd3:    seg_code = SEG_3;
            4'd4:    seg_code = SEG_4;
            4'd5:    seg_code = SEG_5;
            4'd6:    seg_code = SEG_6;
            4'd7:    seg_code = SEG_7;
            4'd8:    seg_code = SEG_8;
            4'd9:    seg_code = SEG_9;
            default: seg_code = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: 8-bit binary to 3-digit BCD in 8 shift cycles.
// start (one cycle) loads bin; done pulses on the 8th shift cycle with bcd holding the finished result.
module bin2bcd_seq
    import vending_disp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  bin,
    output logic [11:0] bcd,
    output logic        done
);

    logic [7:0]  bin_q, bin_d;
    logic [11:0] bcd_q, bcd_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;

    logic [3:0]  adj_u, adj_t, adj_h;
    logic [11:0] bcd_next;

    always_comb begin
        adj_u = (bcd_q[3:0]  >= 4'd5) ? bcd_q[3:0]  + 4'd3 : bcd_q[3:0];
        adj_t = (bcd_q[7:4]  >= 4'd5) ? bcd_q[7:4]  + 4'd3 : bcd_q[7:4];
        adj_h = (bcd_q[11:8] >= 4'd5) ? bcd_q[11:8] + 4'd3 : bcd_q[11:8];
        // The top bit shifts out; for an 8-bit operand it is always zero.
        bcd_next = 12'({adj_h, adj_t, adj_u, bin_q[7]});

        bin_d  = bin_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start) begin
            bin_d  = bin;
            bcd_d  = 12'd0;
            cnt_d  = 3'd0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            bin_d = {bin_q[6:0], 1'b0};
            bcd_d = bcd_next;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                busy_d = 1'b0;
            end
        end
    end

    assign bcd  = bcd_next;
    assign done = busy_q && (cnt_q == 3'd7);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bin_q  <= 8'd0;
            bcd_q  <= 12'd0;
            cnt_q  <= 3'd0;
            busy_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            bcd_q  <= bcd_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/money_display_scan.sv
// Eight-digit multiplexed money display: price on the left, inserted money or change on the right,
// each converted to BCD by one time-shared sequential converter and scanned one digit at a time.
module money_display_scan
    import vending_disp_pkg::*;
#(
    parameter int SCAN_DIV = 100000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [7:0] need_money,
    input  logic [7:0] input_money,
    input  logic [7:0] change_money,
    input  logic       show_change,
    output logic [7:0] Bit_select,
    output logic [7:0] Seg_select
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    conv_state_e state_q, state_d;
    logic [11:0] bcd_l_q, bcd_l_d;
    logic [11:0] bcd_r_q, bcd_r_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  bit_sel_q, bit_sel_d;
    logic [7:0]  seg_sel_q, seg_sel_d;

    logic        conv_start;
    logic [7:0]  conv_bin;
    logic [11:0] conv_bcd;
    logic        conv_done;

    bin2bcd_seq u_bin2bcd (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .start (conv_start),
        .bin   (conv_bin),
        .bcd   (conv_bcd),
        .done  (conv_done)
    );

    // Each LOAD state pulses start for one cycle; the CONV state then waits for done,
    // which marks the only cycle in which that group's display register may change.
    always_comb begin
        state_d    = state_q;
        conv_start = 1'b0;
        conv_bin   = need_money;
        bcd_l_d    = bcd_l_q;
        bcd_r_d    = bcd_r_q;
        case (state_q)
            ST_LOAD_L: begin
                conv_start = 1'b1;
                conv_bin   = need_money;
                state_d    = ST_CONV_L;
            end
            ST_CONV_L: begin
                if (conv_done) begin
                    bcd_l_d = conv_bcd;
                    state_d = ST_LOAD_R;
                end
            end
            ST_LOAD_R: begin
                conv_start = 1'b1;
                conv_bin   = show_change ? change_money : input_money;
                state_d    = ST_CONV_R;
            end
            ST_CONV_R: begin
                if (conv_done) begin
                    bcd_r_d = conv_bcd;
                    state_d = ST_LOAD_L;
                end
            end
            default: state_d = ST_LOAD_L;
        endcase
    end

    always_comb begin
        div_d = div_q + DIV_W'(1);
        idx_d = idx_q;
        if (div_q == DIV_LAST) begin
            div_d = '0;
            idx_d = idx_q + 3'd1;
        end
    end

    // Leading zeros blank per group; embedded zeros (e.g. 100) stay visible.
    always_comb begin
        bit_sel_d = ~(8'd1 << idx_q);
        case (idx_q)
            3'd7: seg_sel_d = (bcd_l_q[11:8] == 4'd0) ? SEG_BLANK : seg_code(bcd_l_q[11:8]);
            3'd6: seg_sel_d = (bcd_l_q[11:4] == 8'd0) ? SEG_BLANK : seg_code(bcd_l_q[7:4]);
            3'd5: seg_sel_d = seg_code(bcd_l_q[3:0]);
            3'd2: seg_sel_d = (bcd_r_q[11:8] == 4'd0) ? SEG_BLANK : seg_code(bcd_r_q[11:8]);
            3'd1: seg_sel_d = (bcd_r_q[11:4] == 8'd0) ? SEG_BLANK : seg_code(bcd_r_q[7:4]);
            3'd0: seg_sel_d = seg_code(bcd_r_q[3:0]);
            default: seg_sel_d = SEG_BLANK;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q   <= ST_LOAD_L;
            bcd_l_q   <= 12'd0;
            bcd_r_q   <= 12'd0;
            div_q     <= '0;
            idx_q     <= 3'd0;
            bit_sel_q <= 8'hFF;
            seg_sel_q <= SEG_BLANK;
        end else begin
            state_q   <= state_d;
            bcd_l_q   <= bcd_l_d;
            bcd_r_q   <= bcd_r_d;
            div_q     <= div_d;
            idx_q     <= idx_d;
            bit_sel_q <= bit_sel_d;
            seg_sel_q <= seg_sel_d;
        end
    end

    assign Bit_select = bit_sel_q;
    assign Seg_select = seg_sel_q;

endmodule

// File: tb/tb_money_display_scan.sv
// Self-checking bench for money_display_scan: directed scenarios plus random values,
// with expected digit codes computed from decimal arithmetic on the displayed amounts.
module tb_money_display_scan;

    localparam int SD = 4;
    localparam logic [7:0] SEG_TBL [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                            8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] need, inm, chg;
    logic       sc;
    logic [7:0] bit_sel, seg_sel;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [7:0] seen [8];

    money_display_scan #(.SCAN_DIV(SD)) dut (
        .sys_clk      (clk),
        .sys_rst_n    (rst_n),
        .need_money   (need),
        .input_money  (inm),
        .change_money (chg),
        .show_change  (sc),
        .Bit_select   (bit_sel),
        .Seg_select   (seg_sel)
    );

    // ---------------- clock / reset-relative cycle count ----------------
    always #5 clk = ~clk;

    // At a negedge, cyc is the index of the next rising edge since reset release;
    // the converter loop is 18 edges long and starts with the need_money capture.
    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] exp_code(int d, int need_v, int right_v);
        int v, pos, h, t, u;
        if (d == 3 || d == 4) return 8'hFF;
        v   = (d >= 5) ? need_v : right_v;
        pos = (d >= 5) ? d - 5 : d;
        h = v / 100;
        t = (v / 10) % 10;
        u = v % 10;
        case (pos)
            2:       return (h == 0) ? 8'hFF : SEG_TBL[h];
            1:       return (h == 0 && t == 0) ? 8'hFF : SEG_TBL[t];
            default: return SEG_TBL[u];
        endcase
    endfunction

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic capture_frame();
        for (int k = 0; k < 8; k++) seen[k] = 8'hxx;
        for (int i = 0; i < 8 * SD; i++) begin
            @(negedge clk);
            for (int k = 0; k < 8; k++) begin
                if (bit_sel === ~(8'h01 << k)) seen[k] = seg_sel;
            end
        end
    endtask

    task automatic check_frame(input string tag, input int need_v, input int right_v);
        capture_frame();
        for (int d = 0; d < 8; d++) begin
            check($sformatf("%s_d%0d", tag, d), seen[d], exp_code(d, need_v, right_v));
        end
    endtask

    task automatic wait_phase(input int ph);
        int guard;
        guard = 0;
        while ((cyc % 18) != ph && guard < 40) begin
            @(negedge clk);
            guard++;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int v_hold, rv_need, rv_in, rv_ch, rv_sc;
        logic [7:0] prev;
        logic [7:0] r;
        bit found;

        rst_n = 1'b0;
        need  = 8'd37;
        inm   = 8'd91;
        chg   = 8'd5;
        sc    = 1'b1;

        // Reset held with nonzero inputs: outputs blank throughout.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("rst_bit_%0d", i), bit_sel, 8'hFF);
            check($sformatf("rst_seg_%0d", i), seg_sel, 8'hFF);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_bit", bit_sel, 8'hFE);
        check("rel_seg", seg_sel, 8'hC0);

        // Normal display.
        need = 8'd123; inm = 8'd45; sc = 1'b0; chg = 8'd0;
        wait_cycles(40);
        check_frame("normal", 123, 45);

        // Change display.
        sc = 1'b1; chg = 8'd7;
        wait_cycles(36);
        check_frame("change", 123, 7);

        // Boundaries.
        need = 8'd0; inm = 8'd255; sc = 1'b0;
        wait_cycles(36);
        check_frame("bound0_255", 0, 255);
        need = 8'd100;
        wait_cycles(36);
        check_frame("bound100", 100, 255);

        // Digit-enable wrap: each value held exactly SD cycles.
        found = 1'b0;
        prev  = bit_sel;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (bit_sel === 8'hFE && prev === 8'h7F) found = 1'b1;
            else prev = bit_sel;
        end
        check("wrap_sync", {7'd0, found}, 8'd1);
        for (int k = 0; k < 9; k++) begin
            for (int c = 0; c < SD; c++) begin
                if (k != 0 || c != 0) @(negedge clk);
                check($sformatf("wrap_k%0d_c%0d", k, c), bit_sel, ~(8'h01 << (k % 8)));
            end
        end

        // need_money scrambled every cycle except at its capture edge.
        v_hold = $urandom_range(1, 255);
        inm    = 8'd58;
        wait_phase(0);
        fork
            begin
                for (int i = 0; i < 80; i++) begin
                    if ((cyc % 18) == 0) begin
                        need = 8'(v_hold);
                    end else begin
                        r = 8'($urandom_range(0, 255));
                        if (r == 8'(v_hold)) r = r ^ 8'h01;
                        need = r;
                    end
                    @(negedge clk);
                end
            end
            begin
                wait_cycles(40);
                check_frame("toggle", v_hold, 58);
            end
        join
        need = 8'(v_hold);

        // Random amounts.
        for (int t = 0; t < 5; t++) begin
            rv_need = $urandom_range(0, 255);
            rv_in   = $urandom_range(0, 255);
            rv_ch   = $urandom_range(0, 255);
            rv_sc   = $urandom_range(0, 1);
            need = 8'(rv_need);
            inm  = 8'(rv_in);
            chg  = 8'(rv_ch);
            sc   = rv_sc[0];
            wait_cycles(40);
            check_frame($sformatf("rand%0d", t), rv_need, (rv_sc != 0) ? rv_ch : rv_in);
        end

        // Reset in the middle of the right-group conversion.
        need = 8'd208; inm = 8'd196; sc = 1'b0;
        wait_cycles(18);
        wait_phase(13);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_bit", bit_sel, 8'hFF);
        check("midrst_seg", seg_sel, 8'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrel_bit", bit_sel, 8'hFE);
        check("midrel_seg", seg_sel, 8'hC0);
        wait_cycles(40);
        check_frame("after_midrst", 208, 196);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
